// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants, pointer-width helper and ID->EX bundle type
package pipe_pkg;

    localparam int PIPE_MAX_DEPTH = 8;

    // Pointer width for a buffer of the given depth; a 1-entry buffer still
    // gets a 1-bit pointer so every vector stays legal.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int PIPE_PTR_W = ptr_w(PIPE_MAX_DEPTH);
    typedef logic [PIPE_PTR_W-1:0] ptr_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [15:0] imm;
        logic [4:0]  rd;
        logic [4:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
        logic        branch;
        logic        jump;
        logic        valid;
    } id_ex_bundle_t;

    localparam int ID_EX_WIDTH = $bits(id_ex_bundle_t);

endpackage

// File: rtl/pipe_buf_mem.sv
// rtl/pipe_buf_mem.sv - DEPTH x WIDTH register array, one write port, async read
//
// Ports:
//   clk        rising-edge clock
//   i_wr_en    write strobe
//   i_wr_addr  write index (0..DEPTH-1)
//   i_wr_data  write payload
//   i_rd_addr  read index (0..DEPTH-1)
//   o_rd_data  combinational read payload
module pipe_buf_mem
    import pipe_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = 2,
    parameter int AW    = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    // Storage carries no reset: contents are only observed behind a valid count.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic valid/ready pipeline stage buffer with flush
//
// Optional feature macro: PIPE_STAGE_BUF_PERF_EN (upstream stall counter).
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush_i      synchronous flush, drops all entries
//   in_valid_i   upstream payload valid
//   in_ready_o   buffer can accept this cycle (registered state only)
//   in_data_i    upstream payload
//   out_valid_o  head entry valid
//   out_ready_i  downstream accepts head
//   out_data_o   head payload, NOP_PAYLOAD when empty
//   count_o      current occupancy
//   stall_cnt_o  saturating count of cycles upstream was held off
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 128,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] NOP_PAYLOAD = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WIDTH-1:0]           in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WIDTH-1:0]           out_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [31:0]                stall_cnt_o
);

    localparam int AW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_rd_data;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
    endfunction

    // Both handshake flags come from the registered count, so backpressure
    // never forms a combinational path from out_ready_i to in_ready_o.
    assign in_ready_o  = (r_count < CW'(DEPTH));
    assign out_valid_o = (r_count != '0);
    assign w_push      = in_valid_i & in_ready_o;
    assign w_pop       = out_valid_o & out_ready_i;

    pipe_buf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push & ~flush_i),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (in_data_i),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    assign out_data_o = out_valid_o ? w_rd_data : NOP_PAYLOAD;
    assign count_o    = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            // A pop in this cycle still completes downstream; a push is dropped.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef PIPE_STAGE_BUF_PERF_EN
    logic [31:0] r_stall_cnt;

    // Survives flush on purpose: it measures backpressure over the whole run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (in_valid_i && !in_ready_o && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - self-checking bench for pipe_stage_buf
module tb_pipe_stage_buf;

`ifdef PIPE_STAGE_BUF_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] count;
    logic [31:0] stall_cnt;

    logic       flush3;
    logic       in_valid3;
    logic       in_ready3;
    logic [7:0] in_data3;
    logic       out_valid3;
    logic       out_ready3;
    logic [7:0] out_data3;
    logic [1:0] count3;
    logic [31:0] stall_cnt3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.WIDTH(8), .DEPTH(2), .NOP_PAYLOAD(8'h00)) u_dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .count_o     (count),
        .stall_cnt_o (stall_cnt)
    );

    pipe_stage_buf #(.WIDTH(8), .DEPTH(3), .NOP_PAYLOAD(8'h00)) u_dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush3),
        .in_valid_i  (in_valid3),
        .in_ready_o  (in_ready3),
        .in_data_i   (in_data3),
        .out_valid_o (out_valid3),
        .out_ready_i (out_ready3),
        .out_data_o  (out_data3),
        .count_o     (count3),
        .stall_cnt_o (stall_cnt3)
    );

    typedef struct packed {
        logic       flush;
        logic       vld;
        logic [7:0] din;
        logic       rdy;
        logic [1:0] cnt;
        logic       ird;
        logic       ovld;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic f, input logic v, input logic [7:0] d, input logic r);
        flush     = f;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk2(input string tag, input logic [1:0] c, input logic ir,
                        input logic ov, input logic [7:0] od);
        chk({tag, ".count"},     32'(count),     32'(c));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".out_data"},  32'(out_data),  32'(od));
    endtask

    byte unsigned q [$];

    initial begin
        //             flush vld  din    rdy  cnt  ird  ovld dout
        vecs[0]  = '{1'b0, 1'b1, 8'hA1, 1'b1, 2'd1, 1'b1, 1'b1, 8'hA1};
        vecs[1]  = '{1'b0, 1'b1, 8'hA2, 1'b1, 2'd1, 1'b1, 1'b1, 8'hA2};
        vecs[2]  = '{1'b0, 1'b1, 8'hA3, 1'b1, 2'd1, 1'b1, 1'b1, 8'hA3};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 1'b1, 1'b0, 8'h00};
        vecs[4]  = '{1'b0, 1'b1, 8'hB1, 1'b0, 2'd1, 1'b1, 1'b1, 8'hB1};
        vecs[5]  = '{1'b0, 1'b1, 8'hB2, 1'b0, 2'd2, 1'b0, 1'b1, 8'hB1};
        vecs[6]  = '{1'b0, 1'b1, 8'hB3, 1'b0, 2'd2, 1'b0, 1'b1, 8'hB1};
        vecs[7]  = '{1'b0, 1'b1, 8'hB3, 1'b1, 2'd1, 1'b1, 1'b1, 8'hB2};
        vecs[8]  = '{1'b0, 1'b1, 8'hB3, 1'b1, 2'd1, 1'b1, 1'b1, 8'hB3};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 1'b1, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 1'b1, 8'hD1, 1'b0, 2'd1, 1'b1, 1'b1, 8'hD1};
        vecs[11] = '{1'b0, 1'b1, 8'hD2, 1'b0, 2'd2, 1'b0, 1'b1, 8'hD1};
        vecs[12] = '{1'b1, 1'b1, 8'hC1, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00};
        vecs[13] = '{1'b0, 1'b1, 8'hE1, 1'b0, 2'd1, 1'b1, 1'b1, 8'hE1};
        vecs[14] = '{1'b1, 1'b1, 8'hC1, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 1'b1, 1'b0, 8'h00};
        vecs[16] = '{1'b0, 1'b1, 8'hF1, 1'b0, 2'd1, 1'b1, 1'b1, 8'hF1};
        vecs[17] = '{1'b1, 1'b1, 8'hF2, 1'b1, 2'd0, 1'b1, 1'b0, 8'h00};
        vecs[18] = '{1'b0, 1'b1, 8'h61, 1'b0, 2'd1, 1'b1, 1'b1, 8'h61};
        vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 1'b1, 1'b0, 8'h00};

        rst_n = 1'b0;
        flush = 0; in_valid = 0; in_data = 0; out_ready = 0;
        flush3 = 0; in_valid3 = 0; in_data3 = 0; out_ready3 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk2("reset", 2'd0, 1'b1, 1'b0, 8'h00);
        chk("reset.stall", stall_cnt, 32'd0);

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].flush, vecs[i].vld, vecs[i].din, vecs[i].rdy);
            chk2($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ird, vecs[i].ovld, vecs[i].dout);
        end
        chk("table.stall", stall_cnt, (PERF != 0) ? 32'd3 : 32'd0);

        // Fill, then hold full with upstream valid for 5 cycles.
        drive(1'b0, 1'b1, 8'h71, 1'b0);
        drive(1'b0, 1'b1, 8'h72, 1'b0);
        repeat (5) drive(1'b0, 1'b1, 8'h73, 1'b0);
        chk2("full_hold", 2'd2, 1'b0, 1'b1, 8'h71);
        chk("full_hold.stall", stall_cnt, (PERF != 0) ? 32'd8 : 32'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk2("drain1", 2'd1, 1'b1, 1'b1, 8'h72);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk2("drain2", 2'd0, 1'b1, 1'b0, 8'h00);

        // DEPTH=3 random handshakes against a queue model.
        for (int i = 0; i < 40; i++) begin
            logic v, r;
            v = 1'($urandom);
            r = 1'($urandom);
            in_valid3  = v;
            in_data3   = 8'(8'h10 + i);
            out_ready3 = r;
            chk($sformatf("d3.count%0d", i), 32'(count3), 32'(q.size()));
            chk($sformatf("d3.in_ready%0d", i), 32'(in_ready3), 32'(q.size() < 3));
            chk($sformatf("d3.out_valid%0d", i), 32'(out_valid3), 32'(q.size() != 0));
            if (r && q.size() != 0) begin
                chk($sformatf("d3.data%0d", i), 32'(out_data3), 32'(q.pop_front()));
            end
            if (v && q.size() < 3 + ((r && out_valid3) ? 1 : 0) && in_ready3) begin
                q.push_back(8'(8'h10 + i));
            end
            @(posedge clk);
            #1;
        end
        in_valid3  = 1'b0;
        out_ready3 = 1'b1;
        for (int i = 0; i < 6 && q.size() != 0; i++) begin
            chk($sformatf("d3.drain%0d", i), 32'(out_data3), 32'(q.pop_front()));
            @(posedge clk);
            #1;
        end
        chk("d3.empty", 32'(count3), 32'd0);
        chk("d3.model_empty", 32'(q.size()), 32'd0);
        out_ready3 = 1'b0;

        // Asynchronous reset in the middle of a cycle with data held.
        drive(1'b0, 1'b1, 8'h91, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk2("async_rst", 2'd0, 1'b1, 1'b0, 8'h00);
        chk("async_rst.stall", stall_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 8'h92, 1'b0);
        chk2("post_rst", 2'd1, 1'b1, 1'b1, 8'h92);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
